rr_mem_arbiter: RTL and testbench

RR_MEM_ARBITER -- requirements
Module: rr_mem_arbiter

---
 rtl/rr_mem_arbiter_pkg.sv | 14 +
 rtl/rr_mem_arbiter_if.sv | 35 +++
 rtl/rr_mem_arbiter_pick.sv | 36 +++
 rtl/rr_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_rr_mem_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_mem_arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter: controller state
// encodings and their width.
package arb_pkg;

    localparam int STATE_W = 2;

    // Encoding 2'b11 is never entered; the controller treats it as IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } arb_state_t;

endpackage

// File: rtl/rr_mem_arbiter_if.sv
// Request/grant bundle between the requestors (master) and the arbiter (slave).
interface rr_mem_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               preempt;
    logic [STATE_W-1:0] arbiter_state;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  preempt,
        input  arbiter_state
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output preempt,
        output arbiter_state
    );

endinterface

// File: rtl/rr_mem_arbiter_pick.sv
// Rotating-priority picker: the first set request strictly after last_idx,
// wrapping around, so the previous grantee is always considered last.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic [NUM_REQ-1:0]         pick,
    output logic [$clog2(NUM_REQ)-1:0] pick_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(last_idx) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any            = 1'b1;
                pick_idx       = cand_idx;
                pick[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin memory arbiter with a hold limit that preempts a grantee under
// contention, and an optional idle turnaround cycle between grants.
module rr_mem_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP_EN   = 1
) (
    input logic             clk,
    input logic             reset_n,
    rr_mem_arbiter_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q;
    logic               preempt_q, preempt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic owner_req;
    logic others_req;
    logic expire;
    logic keep;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req      (bus.req),
        .last_idx (last_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    // The grant is kept only while its owner still asks and the hold limit
    // has not run out against a competing request.
    assign owner_req  = bus.req[idx_q];
    assign others_req = |(bus.req & ~grant_q);
    assign expire     = (hold_q == HOLD_MAX) && others_req;
    assign keep       = owner_req && !expire;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            last_q    <= LAST_RST;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= |grant_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE, GAP: begin
                state_d = pick_any ? GRANT : IDLE;
            end
            GRANT: begin
                if (keep) begin
                    state_d = GRANT;
                end else if (GAP_EN != 0) begin
                    state_d = GAP;
                end else begin
                    state_d = pick_any ? GRANT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With no gap, a released grant hands straight to the next pick; the
    // owner is last in the rotation so a preempted owner cannot win it back.
    always_comb begin
        grant_d   = '0;
        idx_d     = '0;
        preempt_d = 1'b0;
        hold_d    = '0;
        last_d    = last_q;
        case (state_q)
            IDLE, GAP: begin
                if (pick_any) begin
                    grant_d = pick;
                    idx_d   = pick_idx;
                    hold_d  = HOLD_ONE;
                    last_d  = pick_idx;
                end
            end
            GRANT: begin
                if (keep) begin
                    grant_d = grant_q;
                    idx_d   = idx_q;
                    hold_d  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_ONE;
                end else begin
                    preempt_d = owner_req && expire;
                    if ((GAP_EN == 0) && pick_any) begin
                        grant_d = pick;
                        idx_d   = pick_idx;
                        hold_d  = HOLD_ONE;
                        last_d  = pick_idx;
                    end
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = valid_q;
    assign bus.grant_idx     = idx_q;
    assign bus.preempt       = preempt_q;
    assign bus.arbiter_state = state_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench: two arbiters (with and without turnaround gap) against
// an ownership-level model, plus hand-computed directed scenarios.
module tb_rr_mem_arbiter;
    import arb_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int MAX_HOLD   = 4;
    localparam int WAIT_BOUND = (NUM_REQ - 1) * (MAX_HOLD + 1) + 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_REQ-1:0] req = '0;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    rr_mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_a ();
    rr_mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus_b ();

    assign bus_a.req = req;
    assign bus_b.req = req;

    rr_mem_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD), .GAP_EN(1)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    rr_mem_arbiter #(.NUM_REQ(NUM_REQ), .MAX_HOLD(MAX_HOLD), .GAP_EN(0)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after a rising edge and are held for one full cycle.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic rn);
        req     = r;
        reset_n = rn;
        @(posedge clk);
        #1;
    endtask

    // Model: who owns the bus, for how long, whether a turnaround is pending.
    int m_owner[2];
    int m_held[2];
    int m_last[2];
    bit m_gap[2];
    bit m_pre[2];
    bit m_gap_en[2] = '{1'b1, 1'b0};

    task automatic modelPick(input int k);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = (m_last[k] + i) % NUM_REQ;
            if (req[c]) begin
                m_owner[k] = c;
                m_held[k]  = 1;
                m_last[k]  = c;
                return;
            end
        end
    endtask

    task automatic modelStep(input int k);
        logic [NUM_REQ-1:0] one;
        logic [NUM_REQ-1:0] others;
        one = 1;
        if (!reset_n) begin
            m_owner[k] = -1;
            m_held[k]  = 0;
            m_gap[k]   = 1'b0;
            m_last[k]  = NUM_REQ - 1;
            m_pre[k]   = 1'b0;
        end else begin
            m_pre[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                others = req & ~(one << m_owner[k]);
                if (req[m_owner[k]] && !(m_held[k] == MAX_HOLD && others != 0)) begin
                    if (m_held[k] < MAX_HOLD) m_held[k]++;
                end else begin
                    m_pre[k]   = req[m_owner[k]];
                    m_owner[k] = -1;
                    if (m_gap_en[k]) m_gap[k] = 1'b1;
                    else modelPick(k);
                end
            end else begin
                m_gap[k] = 1'b0;
                modelPick(k);
            end
        end
    endtask

    always @(posedge clk) begin
        modelStep(0);
        modelStep(1);
    end

    task automatic compareDut(input int k, input string tag, input logic [NUM_REQ-1:0] g,
                              input logic v, input logic [1:0] idx, input logic p, input logic [1:0] st);
        int eg, ei, es;
        eg = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
        ei = (m_owner[k] >= 0) ? m_owner[k] : 0;
        es = (m_owner[k] >= 0) ? 1 : (m_gap[k] ? 2 : 0);
        checkOutput({tag, ".grant"}, 32'(g), eg);
        checkOutput({tag, ".grant_valid"}, 32'(v), (m_owner[k] >= 0) ? 1 : 0);
        checkOutput({tag, ".grant_idx"}, 32'(idx), ei);
        checkOutput({tag, ".preempt"}, 32'(p), 32'(m_pre[k]));
        checkOutput({tag, ".state"}, 32'(st), es);
    endtask

    // Per-cycle compare, plus the starvation bound on the gapped arbiter.
    int waits[NUM_REQ];
    always @(negedge clk) begin
        if (check_en) begin
            compareDut(0, "a", bus_a.grant, bus_a.grant_valid, bus_a.grant_idx, bus_a.preempt, bus_a.arbiter_state);
            compareDut(1, "b", bus_b.grant, bus_b.grant_valid, bus_b.grant_idx, bus_b.preempt, bus_b.arbiter_state);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (reset_n && req[i] && !bus_a.grant[i]) begin
                    waits[i]++;
                    checkOutput($sformatf("wait_bound[%0d]", i), 32'(waits[i] > WAIT_BOUND), 0);
                end else begin
                    waits[i] = 0;
                end
            end
        end
    end

    task automatic resetDut();
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b0);
    endtask

    int exp029[21] = '{1, 1, 1, 1, 0, 2, 2, 2, 2, 0, 4, 4, 4, 4, 0, 8, 8, 8, 8, 0, 1};

    initial begin
        logic [NUM_REQ-1:0] r;

        applyStimulus('0, 1'b0);
        check_en = 1'b1;
        applyStimulus('0, 1'b0);
        checkOutput("reset.grant", 32'(bus_a.grant), 0);
        checkOutput("reset.valid", 32'(bus_a.grant_valid), 0);
        checkOutput("reset.state", 32'(bus_a.arbiter_state), 0);
        checkOutput("reset.preempt", 32'(bus_a.preempt), 0);

        $display("[TB] all requestors held");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(4'b1111, 1'b1);
            checkOutput($sformatf("rr.grant[%0d]", i), 32'(bus_a.grant), exp029[i]);
            checkOutput($sformatf("rr.preempt[%0d]", i), 32'(bus_a.preempt), (exp029[i] == 0) ? 1 : 0);
        end

        $display("[TB] sole requestor");
        resetDut();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0100, 1'b1);
            checkOutput($sformatf("sole.grant[%0d]", i), 32'(bus_a.grant), 4);
            checkOutput($sformatf("sole.preempt[%0d]", i), 32'(bus_a.preempt), 0);
        end
        checkOutput("sole.idx", 32'(bus_a.grant_idx), 2);

        $display("[TB] short request then release");
        resetDut();
        applyStimulus(4'b0001, 1'b1);
        checkOutput("short.grant1", 32'(bus_a.grant), 1);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("short.grant2", 32'(bus_a.grant), 1);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("short.gap_grant", 32'(bus_a.grant), 0);
        checkOutput("short.gap_state", 32'(bus_a.arbiter_state), 2);
        applyStimulus(4'b0000, 1'b1);
        checkOutput("short.idle_state", 32'(bus_a.arbiter_state), 0);

        $display("[TB] reset during grant");
        resetDut();
        applyStimulus(4'b0100, 1'b1);
        checkOutput("midrst.before", 32'(bus_a.grant), 4);
        applyStimulus(4'b1001, 1'b0);
        checkOutput("midrst.grant", 32'(bus_a.grant), 0);
        checkOutput("midrst.state", 32'(bus_a.arbiter_state), 0);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("midrst.after", 32'(bus_a.grant), 1);

        $display("[TB] direct handoff without gap");
        resetDut();
        applyStimulus(4'b1010, 1'b1);
        checkOutput("handoff.first", 32'(bus_b.grant), 2);
        applyStimulus(4'b1000, 1'b1);
        checkOutput("handoff.second", 32'(bus_b.grant), 8);
        checkOutput("handoff.preempt", 32'(bus_b.preempt), 0);
        checkOutput("handoff.state", 32'(bus_b.arbiter_state), 1);

        $display("[TB] random traffic");
        resetDut();
        r = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < NUM_REQ; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            applyStimulus(r, 1'b1);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
